// File: rtl/tree_loader_if.sv
// Byte-stream and tree-RAM write-port bundle for the tree loader.
// The slave side is the loader; the master side is the host/bench.
interface tree_loader_if #(
   parameter int WIDTH = 8
);
   logic               load_start_i;
   logic [WIDTH-1:0]   byte_i;
   logic               byte_valid_i;
   logic               byte_ready_o;
   logic               wr_en_o;
   logic [WIDTH-1:0]   wr_adr_o;
   logic [WIDTH*4:0]   wr_data_o;
   logic               busy_o;
   logic               done_o;
   logic               err_o;
   logic [WIDTH-1:0]   node_cnt_o;

   modport slave (
      input  load_start_i, byte_i, byte_valid_i,
      output byte_ready_o, wr_en_o, wr_adr_o, wr_data_o,
             busy_o, done_o, err_o, node_cnt_o
   );

   modport master (
      output load_start_i, byte_i, byte_valid_i,
      input  byte_ready_o, wr_en_o, wr_adr_o, wr_data_o,
             busy_o, done_o, err_o, node_cnt_o
   );
endinterface

// File: rtl/tree_loader.sv
// Loads decision-tree node records from a byte stream into the tree RAM,
// one packed word per node, rejecting decision nodes with out-of-range targets.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for load_start_i
// HDR     | waiting for the node-count header byte N
// COLLECT | accepting the 5 record bytes of the current node
// WRITE   | one-cycle RAM write of the assembled node word
// DONE    | one-cycle completion pulse
// ERR     | one-cycle error state, err_o becomes sticky
module tree_loader #(
   parameter int WIDTH = 8
) (
   input  logic         clock,
   input  logic         reset,
   tree_loader_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      HDR     = 3'd1,
      COLLECT = 3'd2,
      WRITE   = 3'd3,
      DONE    = 3'd4,
      ERR     = 3'd5
   } state_t;

   state_t             r_state;
   state_t             w_next;

   logic [WIDTH-1:0]   r_n;
   logic [2:0]         r_idx;
   logic               r_type;
   logic [WIDTH-1:0]   r_cmp;
   logic [WIDTH-1:0]   r_nt;
   logic [WIDTH-1:0]   r_nf;
   logic [WIDTH*4:0]   r_wr_data;
   logic [WIDTH-1:0]   r_wr_adr;
   logic [WIDTH-1:0]   r_node_cnt;
   logic               r_err;
   logic               r_ready;
   logic               r_wr_en;
   logic               r_busy;
   logic               r_done;

   logic               w_accept;
   logic               w_last_byte;
   logic               w_chk_fail;
   logic [WIDTH-1:0]   w_cnt_inc;

   assign w_accept    = bus.byte_valid_i && r_ready;
   assign w_last_byte = (r_idx == 3'd4);
   // Only decision nodes have their branch targets range-checked.
   assign w_chk_fail  = r_type && ((r_nt >= r_n) || (r_nf >= r_n));
   assign w_cnt_inc   = r_node_cnt + 1'b1;

   always_ff @(posedge clock) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (bus.load_start_i) w_next = HDR;
         HDR:     if (w_accept) w_next = (bus.byte_i == '0) ? ERR : COLLECT;
         COLLECT: if (w_accept && w_last_byte) w_next = w_chk_fail ? ERR : WRITE;
         WRITE:   w_next = (w_cnt_inc == r_n) ? DONE : COLLECT;
         DONE:    w_next = IDLE;
         ERR:     w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_n        <= '0;
         r_idx      <= '0;
         r_type     <= 1'b0;
         r_cmp      <= '0;
         r_nt       <= '0;
         r_nf       <= '0;
         r_wr_data  <= '0;
         r_wr_adr   <= '0;
         r_node_cnt <= '0;
         r_err      <= 1'b0;
         r_ready    <= 1'b0;
         r_wr_en    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         if (r_state == IDLE && bus.load_start_i) begin
            r_err      <= 1'b0;
            r_node_cnt <= '0;
            r_idx      <= '0;
         end
         if (r_state == HDR && w_accept) r_n <= bus.byte_i;
         if (r_state == COLLECT && w_accept) begin
            r_idx <= w_last_byte ? 3'd0 : r_idx + 3'd1;
            unique case (r_idx)
               3'd0:    r_type <= bus.byte_i[0];
               3'd1:    r_cmp  <= bus.byte_i;
               3'd2:    r_nt   <= bus.byte_i;
               3'd3:    r_nf   <= bus.byte_i;
               default: begin
                  r_wr_data <= {r_type, r_cmp, r_nt, r_nf, bus.byte_i};
                  r_wr_adr  <= r_node_cnt;
               end
            endcase
         end
         if (r_state == WRITE) r_node_cnt <= w_cnt_inc;
         if (w_next == ERR) r_err <= 1'b1;
         // Status outputs are registered from the next state so they align with it.
         r_ready <= (w_next == HDR) || (w_next == COLLECT);
         r_wr_en <= (w_next == WRITE);
         r_busy  <= (w_next != IDLE);
         r_done  <= (w_next == DONE);
      end
   end

   assign bus.byte_ready_o = r_ready;
   assign bus.wr_en_o      = r_wr_en;
   assign bus.wr_adr_o     = r_wr_adr;
   assign bus.wr_data_o    = r_wr_data;
   assign bus.busy_o       = r_busy;
   assign bus.done_o       = r_done;
   assign bus.err_o        = r_err;
   assign bus.node_cnt_o   = r_node_cnt;

endmodule

// File: tb/tb_tree_loader.sv
// Bench for tree_loader: randomized byte stalls against a record-level model
// of the expected RAM writes, error outcome and completion timing.
module tb_tree_loader;
   typedef logic [7:0] byte_t;

   logic clock = 1'b0;
   logic reset = 1'b1;

   tree_loader_if #(.WIDTH(8)) bus ();
   tree_loader #(.WIDTH(8)) dut (.clock(clock), .reset(reset), .bus(bus));

   always #5 clock = ~clock;

   int n_total = 0;
   int n_pass  = 0;

   int ncyc     = 0;
   int t_start  = -100;
   int done_rel = -1;
   int err_rel  = -1;
   int n_done   = 0;
   logic prev_err = 1'b0;
   logic [32:0] first_word = '0;

   logic [7:0]  exp_adr[$];
   logic [32:0] exp_data[$];
   bit exp_err;
   bit exp_done;
   int exp_cnt;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", name, act, exp);
   endtask

   // Record-level model: which nodes get written, and how the load ends.
   task automatic model(input byte_t q[$], input int limit);
      int n;
      exp_adr.delete();
      exp_data.delete();
      exp_err  = 0;
      exp_done = 0;
      exp_cnt  = 0;
      if (limit < 1) return;
      n = q[0];
      if (n == 0) begin exp_err = 1; return; end
      for (int i = 0; i < n; i++) begin
         int b;
         b = 1 + 5 * i;
         if (b + 5 > limit) return;
         if (q[b][0] && (q[b+2] >= n || q[b+3] >= n)) begin exp_err = 1; return; end
         exp_adr.push_back(8'(i));
         exp_data.push_back({q[b][0], q[b+1], q[b+2], q[b+3], q[b+4]});
         exp_cnt++;
      end
      exp_done = 1;
   endtask

   always @(negedge clock) begin
      ncyc++;
      if (!reset) begin
         if (bus.load_start_i && !bus.busy_o) begin
            t_start  = ncyc;
            n_done   = 0;
            done_rel = -1;
            err_rel  = -1;
         end
         if (ncyc == t_start + 1) begin
            check("hdr_err_clear", bus.err_o, 0);
            check("hdr_cnt_clear", bus.node_cnt_o, 0);
            check("hdr_ready", bus.byte_ready_o, 1);
            check("hdr_busy", bus.busy_o, 1);
         end
         check("wr_done_excl", bus.wr_en_o & bus.done_o, 0);
         if (bus.wr_en_o) begin
            if (exp_adr.size() == 0) check("unexpected_write", bus.wr_en_o, 0);
            else begin
               check("wr_adr", bus.wr_adr_o, exp_adr[0]);
               check("wr_data", bus.wr_data_o, exp_data[0]);
               check("adr_eq_cnt", bus.node_cnt_o, exp_adr[0]);
               if (bus.wr_adr_o == 8'd0) first_word = bus.wr_data_o;
               void'(exp_adr.pop_front());
               void'(exp_data.pop_front());
            end
         end
         if (bus.done_o) begin n_done++; done_rel = ncyc - t_start; end
         if (bus.err_o && !prev_err) err_rel = ncyc - t_start;
         prev_err = bus.err_o;
      end
   end

   task automatic run_load(input byte_t q[$], input int limit, input int stall_pct,
                           input bit glitch, output int stalls);
      int sent = 0;
      int budget = 0;
      bit acc = 0;
      stalls = 0;
      model(q, limit);
      @(negedge clock);
      bus.load_start_i = 1'b1;
      @(negedge clock);
      while (budget < 3000) begin
         bus.load_start_i = 1'b0;
         if (glitch && sent == 8) bus.load_start_i = 1'b1;
         if (glitch && bus.busy_o && (bus.done_o || bus.err_o)) bus.load_start_i = 1'b1;
         if (sent < limit) begin
            bus.byte_i       = q[sent];
            bus.byte_valid_i = ($urandom_range(99) >= stall_pct);
            if (!bus.byte_valid_i && bus.byte_ready_o) stalls++;
         end else bus.byte_valid_i = 1'b0;
         acc = bus.byte_valid_i && bus.byte_ready_o;
         @(negedge clock);
         if (acc) sent++;
         if (limit < q.size() && sent >= limit) break;
         if (!bus.busy_o) break;
         budget++;
      end
      bus.load_start_i = 1'b0;
      bus.byte_valid_i = 1'b0;
      if (budget >= 3000) check("load_timeout", budget, 0);
   endtask

   task automatic post_checks();
      check("writes_outstanding", exp_adr.size(), 0);
      check("err_final", bus.err_o, exp_err);
      check("done_count", n_done, exp_done ? 1 : 0);
      check("node_cnt_final", bus.node_cnt_o, exp_cnt);
      check("idle_busy", bus.busy_o, 0);
   endtask

   task automatic check_reset_vals();
      check("rst_ready", bus.byte_ready_o, 0);
      check("rst_wr_en", bus.wr_en_o, 0);
      check("rst_busy", bus.busy_o, 0);
      check("rst_done", bus.done_o, 0);
      check("rst_err", bus.err_o, 0);
      check("rst_adr", bus.wr_adr_o, 0);
      check("rst_data", bus.wr_data_o, 0);
      check("rst_cnt", bus.node_cnt_o, 0);
   endtask

   initial begin
      byte_t s3[$];
      byte_t s0[$];
      byte_t sbad[$];
      byte_t sout[$];
      byte_t sbad1[$];
      int st;

      s3    = '{8'h03, 8'h01, 8'h80, 8'h01, 8'h02, 8'h00,
                8'h00, 8'h00, 8'h00, 8'h00, 8'hAA,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h55};
      s0    = '{8'h00};
      sbad  = '{8'h02, 8'h01, 8'h10, 8'h00, 8'h05, 8'h00,
                8'h00, 8'h00, 8'hFF, 8'hFF, 8'h12};
      sout  = '{8'h02, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h12,
                8'h01, 8'h05, 8'h00, 8'h01, 8'h00};
      sbad1 = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
                8'h01, 8'h00, 8'h07, 8'h00, 8'h00};

      bus.load_start_i = 1'b0;
      bus.byte_i       = '0;
      bus.byte_valid_i = 1'b0;
      repeat (3) @(negedge clock);
      check_reset_vals();
      reset = 1'b0;

      model(s3, s3.size());
      check("model_nwrites", exp_adr.size(), 3);
      check("model_word2", exp_data[2], 33'h0_00_00_00_55);

      run_load(s3, s3.size(), 0, 0, st);
      post_checks();
      check("done_cycle_nostall", done_rel, 20);
      check("word0_literal", first_word, 33'h1_80_01_02_00);
      check("cnt_literal", bus.node_cnt_o, 3);

      run_load(s3, s3.size(), 50, 0, st);
      post_checks();
      check("done_cycle_stall", done_rel, 20 + st);

      run_load(s0, s0.size(), 0, 0, st);
      post_checks();
      check("hdr0_err_cycle", err_rel, 2);

      run_load(sbad, sbad.size(), 0, 0, st);
      post_checks();
      check("badrec_cnt_literal", bus.node_cnt_o, 0);

      run_load(sout, sout.size(), 30, 0, st);
      post_checks();
      check("outnode_word_literal", first_word, 33'h0_00_FF_FF_12);

      run_load(s3, 9, 0, 0, st);
      reset = 1'b1;
      @(negedge clock);
      check_reset_vals();
      check("pre_reset_writes", exp_adr.size(), 0);
      reset = 1'b0;
      run_load(s3, s3.size(), 0, 0, st);
      post_checks();
      check("after_reset_done_cycle", done_rel, 20);

      run_load(s3, s3.size(), 30, 1, st);
      post_checks();
      repeat (3) @(negedge clock);
      check("glitch_done_idle", bus.busy_o, 0);
      check("glitch_done_cnt", bus.node_cnt_o, 3);

      run_load(sbad1, sbad1.size(), 30, 1, st);
      post_checks();
      repeat (3) @(negedge clock);
      check("glitch_err_held", bus.err_o, 1);
      check("glitch_err_cnt", bus.node_cnt_o, 1);
      check("glitch_err_idle", bus.busy_o, 0);

      run_load(s3, s3.size(), 0, 0, st);
      post_checks();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/tree_loader.md
# tree_loader

Programs the decision-tree node memory that the `decision` engine walks. It accepts a byte stream over a valid/ready handshake: one header byte giving the node count N, then N five-byte node records. It assembles each record into one node word, range-checks its branch targets, and issues one write per node on the tree RAM write port. It sits between the host/config interface and the tree RAM, upstream of `decision`.

## Interface
- `WIDTH`, 8: byte, field and address width. Node word is `WIDTH*4+1` bits.
- `clock` in 1: single clock. All logic is on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `load_start_i` in 1: begins a load when sampled high in IDLE. Ignored in every other state.
- `byte_i` in WIDTH: stream data.
- `byte_valid_i` in 1: `byte_i` is valid.
- `byte_ready_o` out 1: loader can accept a byte. A transfer occurs when valid && ready.
- `wr_en_o` out 1: RAM write strobe, one cycle per node.
- `wr_adr_o` out WIDTH: node address, 0..N-1.
- `wr_data_o` out WIDTH*4+1: packed node word.
- `busy_o` out 1: high in any state other than IDLE.
- `done_o` out 1: one-cycle pulse when all N nodes have been written without error.
- `err_o` out 1: sticky error flag. Cleared by reset or by the next accepted `load_start_i`.
- `node_cnt_o` out WIDTH: number of nodes written so far in the current load.

## Operation
- States:
  - IDLE: `load_start_i` goes to HDR, clears `err_o` and `node_cnt_o`.
  - HDR: waits for the header byte N. N==0 goes to ERR; otherwise latch N and go to COLLECT.
  - COLLECT: accepts 5 bytes, byte index k=0..4. After k=4, go to WRITE, or to ERR if the check fails.
  - WRITE: one cycle. Then DONE if `node_cnt` == N after increment, else COLLECT.
  - DONE: one cycle, then IDLE.
  - ERR: one cycle, then IDLE.
- Record byte order: flags, cmp, next_T, next_F, y_out.
  - flags bit0 is node_type: 1 = DECISION_NODE, 0 = OUT_NODE. Flags bits [WIDTH-1:1] are ignored.
- Node word packing:
  - `wr_data_o[WIDTH*4]` = node_type
  - `[WIDTH*4-1:WIDTH*3]` = cmp
  - `[WIDTH*3-1:WIDTH*2]` = next_T
  - `[WIDTH*2-1:WIDTH]` = next_F
  - `[WIDTH-1:0]` = y_out
- Check, decision nodes only: both next_T and next_F must be < N. Failing records are not written. Out-node targets are not checked.
- `wr_adr_o` equals `node_cnt_o` during WRITE. `node_cnt_o` increments at the end of WRITE (unsigned, never wraps since N ≤ 2^WIDTH-1).
- `byte_ready_o` is 1 only in HDR and COLLECT. It is 0 in IDLE, WRITE, DONE and ERR, so no bytes are accepted there.
- `err_o` is set entering ERR and held until cleared as described in the Interface.
- The loader never clears RAM. Entries written before an error or a reset remain in the RAM.

## Timing
- Reset values: state IDLE; `byte_ready_o`, `wr_en_o`, `busy_o`, `done_o`, `err_o` = 0; `wr_adr_o`, `wr_data_o`, `node_cnt_o` = 0.
- `load_start_i` high in IDLE at edge t puts the loader in HDR at t+1, with `byte_ready_o`=1 from t+1.
- Byte stalls (`byte_valid_i` low) hold the state indefinitely. There is no timeout.
- After the 5th record byte is accepted at edge e, `wr_en_o`=1 during the cycle after e, with address and data stable in that cycle only.
- Minimum load length with zero stalls:
  - 1 (start) + 1 (header) + 6N cycles
  - plus `done_o` high for one cycle, one cycle after the last WRITE.
- Outputs are registered. `wr_en_o` and `done_o` are never high in the same cycle.
- `reset` mid-load: next cycle is IDLE, all outputs take reset values, and any partial record is discarded.
- `load_start_i` while `busy_o`=1: ignored, with no effect on the load in progress.
- `load_start_i` in the DONE or ERR cycle: ignored. It must be reasserted once IDLE is reached.

## Test plan
- Three-node tree. Header 3; records {01,80,01,02,00}, {00,00,00,00,AA}, {00,00,00,00,55}, no stalls:
  - 3 writes at addresses 0,1,2; word0 = 1_80_01_02_00.
  - `done_o` pulse at cycle 20 after start; `err_o`=0; `node_cnt_o`=3.
- Same stream with `byte_valid_i` toggled 50%: identical writes and data; `done_o` arrives later; no byte lost or duplicated.
- Header 0: `err_o`=1 one cycle after the header is accepted; no `wr_en_o`; return to IDLE.
- Header 2; record0 {01,10,00,05,00}:
  - next_F=5 ≥ 2, so `err_o`=1 with no write for node 0; `node_cnt_o`=0.
  - Out-node record {00,00,FF,FF,12} in a valid load is written without error.
- `reset` asserted after 3 bytes of record 1 of an N=3 load: next cycle all outputs at reset values. A new load then completes normally from address 0.
- `load_start_i` pulsed during COLLECT and during DONE: no restart, `err_o` and `node_cnt_o` unaffected; a start in IDLE afterwards clears `err_o`.
